// File: rtl/slave_fifo.sv
// slave_fifo: per-channel input buffer of the multi-channel data formatter.
//
// Words from the external channel interface go into a DEPTH-entry FIFO.
// When at least one full packet (length chosen by slv_pkglen_i) is buffered,
// a2s_req_o is raised. A one-cycle a2s_grant_i then streams exactly one
// packet, one word per cycle, on registered outputs.
//
// Ports:
//   clk_i         system clock, rising edge
//   rstn_i        asynchronous active-low reset
//   chnl_valid_i  channel word valid
//   chnl_data_i   channel write data
//   chnl_ready_o  FIFO accepts a word this cycle (combinational)
//   slv_en_i      channel enable
//   slv_pkglen_i  packet length code: 0->4, 1->8, 2->16, 3..7->32 words
//   a2s_grant_i   arbiter grant, one-cycle pulse
//   a2s_req_o     full packet available (combinational, IDLE only)
//   a2s_val_o     output word valid (registered)
//   a2s_data_o    output word, zero whenever a2s_val_o is low
//   a2s_eop_o     last word of packet
//   margin_o      free entries, DEPTH - count, registered
//
// Handshakes: the input side is valid/ready -- a word transfers on every
// rising edge where chnl_valid_i && chnl_ready_o. The output side has no
// backpressure: after a grant, a2s_val_o is high for exactly L consecutive
// cycles and the consumer must take every word.
module slave_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 64,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  chnl_valid_i,
  input  logic [DATA_WIDTH-1:0] chnl_data_i,
  output logic                  chnl_ready_o,
  input  logic                  slv_en_i,
  input  logic [2:0]            slv_pkglen_i,
  input  logic                  a2s_grant_i,
  output logic                  a2s_req_o,
  output logic                  a2s_val_o,
  output logic [DATA_WIDTH-1:0] a2s_data_o,
  output logic                  a2s_eop_o,
  output logic [ADDR_WIDTH:0]   margin_o
);

  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);

  typedef enum logic {IDLE, SEND} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH:0]   rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count;
  logic [5:0]            len_dec;
  logic [5:0]            len_q, len_d;
  logic [5:0]            beat_q, beat_d;
  logic                  push;
  logic                  pop;
  logic                  last;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Pointers carry one extra bit so that full and empty are distinguishable.
  assign count        = wr_ptr_q - rd_ptr_q;
  assign chnl_ready_o = rstn_i && slv_en_i && (count != DEPTH_C);
  assign push         = chnl_valid_i && chnl_ready_o;
  assign pop          = (state_q == SEND);

  always_comb begin
    case (slv_pkglen_i)
      3'd0:    len_dec = 6'd4;
      3'd1:    len_dec = 6'd8;
      3'd2:    len_dec = 6'd16;
      default: len_dec = 6'd32;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    beat_d    = beat_q;
    a2s_req_o = 1'b0;
    last      = 1'b0;
    case (state_q)
      IDLE: begin
        a2s_req_o = rstn_i && slv_en_i &&
                    (count >= (ADDR_WIDTH+1)'(len_dec));
        if (a2s_req_o && a2s_grant_i) begin
          // Length is frozen here so pkglen changes cannot reshape a packet.
          state_d = SEND;
          len_d   = len_dec;
          beat_d  = '0;
        end
      end
      SEND: begin
        last   = (beat_q == len_q - 6'd1);
        beat_d = beat_q + 6'd1;
        if (last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign wr_ptr_d = wr_ptr_q + (ADDR_WIDTH+1)'(push);
  assign rd_ptr_d = rd_ptr_q + (ADDR_WIDTH+1)'(pop);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      len_q      <= '0;
      beat_q     <= '0;
      a2s_val_o  <= 1'b0;
      a2s_data_o <= '0;
      a2s_eop_o  <= 1'b0;
      margin_o   <= DEPTH_C;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      len_q      <= len_d;
      beat_q     <= beat_d;
      a2s_val_o  <= pop;
      a2s_data_o <= pop ? mem[rd_ptr_q[ADDR_WIDTH-1:0]] : '0;
      a2s_eop_o  <= last;
      // Margin reflects this edge's push and pop, not the previous count.
      margin_o   <= DEPTH_C - (wr_ptr_d - rd_ptr_d);
    end
  end

  // Storage is not reset; the pointers define which entries are live.
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr_q[ADDR_WIDTH-1:0]] <= chnl_data_i;
  end

endmodule

// File: tb/tb_slave_fifo.sv
module tb_slave_fifo;
  localparam int DW    = 32;
  localparam int DEPTH = 64;
  localparam int AW    = 6;

  // ---------------- clock / reset ----------------
  logic          clk    = 1'b0;
  logic          rst_n  = 1'b0;
  logic          valid  = 1'b0;
  logic [DW-1:0] wdata  = '0;
  logic          en     = 1'b1;
  logic [2:0]    pkglen = 3'd0;
  logic          grant  = 1'b0;
  logic          ready;
  logic          req;
  logic          oval;
  logic [DW-1:0] odata;
  logic          oeop;
  logic [AW:0]   margin;

  always #5 clk = ~clk;

  slave_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
    .clk_i        (clk),
    .rstn_i       (rst_n),
    .chnl_valid_i (valid),
    .chnl_data_i  (wdata),
    .chnl_ready_o (ready),
    .slv_en_i     (en),
    .slv_pkglen_i (pkglen),
    .a2s_grant_i  (grant),
    .a2s_req_o    (req),
    .a2s_val_o    (oval),
    .a2s_data_o   (odata),
    .a2s_eop_o    (oeop),
    .margin_o     (margin)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard / model ----------------
  int            n_checks = 0;
  int            n_pass   = 0;
  bit            chk_en   = 1'b0;

  logic [DW-1:0] exp_q[$];
  bit            m_send   = 1'b0;
  int            m_left   = 0;
  logic          m_val    = 1'b0;
  logic          m_eop    = 1'b0;
  logic [DW-1:0] m_data   = '0;
  int            m_margin = DEPTH;
  bit            m_push;
  bit            m_rq;

  function automatic int len_of(logic [2:0] p);
    return (p >= 3'd3) ? 32 : (4 << p);
  endfunction

  function automatic bit m_ready();
    return rst_n && en && (exp_q.size() < DEPTH);
  endfunction

  function automatic bit m_req();
    return rst_n && !m_send && en && (exp_q.size() >= len_of(pkglen));
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      m_send   = 1'b0;
      m_left   = 0;
      m_val    = 1'b0;
      m_eop    = 1'b0;
      m_data   = '0;
      m_margin = DEPTH;
    end else begin
      m_push = valid && m_ready();
      m_rq   = m_req();
      if (m_send) begin
        m_data = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        m_val  = 1'b1;
        m_eop  = (m_left == 1);
        m_left--;
        if (m_left == 0) m_send = 1'b0;
      end else begin
        m_val  = 1'b0;
        m_data = '0;
        m_eop  = 1'b0;
        if (grant && m_rq) begin
          m_send = 1'b1;
          m_left = len_of(pkglen);
        end
      end
      if (m_push) exp_q.push_back(wdata);
      m_margin = DEPTH - exp_q.size();
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("ready",  ready,  m_ready());
      check("req",    req,    m_req());
      check("val",    oval,   m_val);
      check("data",   odata,  m_data);
      check("eop",    oeop,   m_eop);
      check("margin", margin, m_margin);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic push_n(int n, logic [DW-1:0] base, bit rnd);
    valid = 1'b1;
    for (int i = 0; i < n; i++) begin
      wdata = rnd ? DW'($urandom) : base + DW'(i);
      cycle();
    end
    valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    cycle();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    repeat (2) cycle();
    chk_en = 1'b1;
    rst_n  = 1'b1;
    cycle();
    @(negedge clk);
    check("lit_reset_margin", margin, 64);
    check("lit_reset_ready",  ready,  1);
    check("lit_reset_req",    req,    0);
    check("lit_reset_val",    oval,   0);

    // four-word packet
    pkglen = 3'd0;
    push_n(4, 32'hA0, 1'b0);
    @(negedge clk);
    check("lit_pkt4_req",    req,    1);
    check("lit_pkt4_margin", margin, 60);
    grant = 1'b1;
    cycle();
    grant = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cycle();
      @(negedge clk);
      check("lit_pkt4_val",  oval,  1);
      check("lit_pkt4_data", odata, 32'hA0 + i);
      check("lit_pkt4_eop",  oeop,  (i == 3));
    end
    check("lit_pkt4_margin_end", margin, 64);

    // fill to full with valid held past full
    push_n(66, '0, 1'b1);
    @(negedge clk);
    check("lit_full_ready",  ready,  0);
    check("lit_full_margin", margin, 0);
    pkglen = 3'd3;
    grant  = 1'b1;
    cycle();
    grant  = 1'b0;
    repeat (32) cycle();
    @(negedge clk);
    check("lit_half_margin", margin, 32);
    check("lit_half_ready",  ready,  1);
    grant = 1'b1;
    cycle();
    grant = 1'b0;
    repeat (32) cycle();

    // push continuously during an 8-word send
    pkglen = 3'd1;
    push_n(8, '0, 1'b1);
    @(negedge clk);
    check("lit_ovl_margin_pre", margin, 56);
    valid = 1'b1;
    wdata = DW'($urandom);
    grant = 1'b1;
    cycle();
    grant = 1'b0;
    for (int i = 0; i < 8; i++) begin
      wdata = DW'($urandom);
      cycle();
    end
    valid = 1'b0;
    @(negedge clk);
    check("lit_ovl_margin_post", margin, 55);

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      valid = 1'($urandom_range(0, 1));
      wdata = DW'($urandom);
      grant = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 15) == 0) pkglen = 3'($urandom_range(0, 7));
      en = ($urandom_range(0, 19) != 0);
      cycle();
    end
    valid = 1'b0;
    grant = 1'b0;
    en    = 1'b1;

    // pkglen change and disable mid-packet
    do_reset();
    pkglen = 3'd0;
    push_n(36, 32'h100, 1'b0);
    @(negedge clk);
    check("lit_dis_margin", margin, 28);
    grant = 1'b1;
    cycle();
    grant  = 1'b0;
    pkglen = 3'd3;
    en     = 1'b0;
    cycle();
    @(negedge clk);
    check("lit_dis_ready", ready, 0);
    check("lit_dis_req",   req,   0);
    check("lit_dis_data0", odata, 32'h100);
    repeat (3) cycle();
    @(negedge clk);
    check("lit_dis_eop",   oeop,  1);
    check("lit_dis_data3", odata, 32'h103);
    cycle();
    @(negedge clk);
    check("lit_dis_idle_req", req,  0);
    check("lit_dis_idle_val", oval, 0);
    en = 1'b1;
    @(negedge clk);
    check("lit_reen_req", req, 1);
    cycle();

    // reset in the middle of an 8-word packet
    do_reset();
    pkglen = 3'd1;
    push_n(16, 32'h200, 1'b0);
    grant = 1'b1;
    cycle();
    grant = 1'b0;
    cycle();
    cycle();
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    check("lit_mid_rst_val",    oval,   0);
    check("lit_mid_rst_data",   odata,  0);
    check("lit_mid_rst_eop",    oeop,   0);
    check("lit_mid_rst_margin", margin, 64);
    check("lit_mid_rst_req",    req,    0);
    cycle();
    rst_n  = 1'b1;
    pkglen = 3'd0;
    push_n(4, 32'hB0, 1'b0);
    grant = 1'b1;
    cycle();
    grant = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cycle();
      @(negedge clk);
      check("lit_post_rst_data", odata, 32'hB0 + i);
    end
    check("lit_post_rst_margin", margin, 64);
    cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
